// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the writeback path: result source selects,
// load funct3 encodings and the queued writeback entry.
package riscv_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Two-entry synchronous FIFO of formatted writeback entries; the head is
// presented combinationally from storage.
module wb_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  wb_entry_t  mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 2'(DEPTH));
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writer: formats completed results, buffers them in a
// two-entry queue, drives the write port and tracks pending writes per register.
module writeback_unit
  import riscv_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int CW     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [4:0]  res_rd,
  input  logic [1:0]  res_sel,
  input  logic [31:0] res_alu,
  input  logic [31:0] res_load,
  input  logic [31:0] res_pc4,
  input  logic [2:0]  res_funct3,
  input  logic        wb_hold,
  output logic        rf_we,
  output logic [4:0]  rf_rd_addr,
  output logic [31:0] rf_rd_din,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic [31:0] busy_mask
);

  logic [CW-1:0] cnt [32];
  logic          rdy_en;
  logic          q_full;
  logic          q_empty;
  logic          push;
  logic          issue_fire;
  logic [31:0]   load_fmt;
  logic [31:0]   inc_vec;
  logic [31:0]   dec_vec;
  wb_entry_t     push_entry;
  wb_entry_t     head;
  wb_entry_t     last_entry;

  always_comb begin
    case (res_funct3)
      F3_LB:   load_fmt = {{24{res_load[7]}}, res_load[7:0]};
      F3_LH:   load_fmt = {{16{res_load[15]}}, res_load[15:0]};
      F3_LBU:  load_fmt = {24'd0, res_load[7:0]};
      F3_LHU:  load_fmt = {16'd0, res_load[15:0]};
      default: load_fmt = res_load;
    endcase
  end

  always_comb begin
    push_entry.rd = res_rd;
    case (res_sel)
      WB_SEL_LOAD: push_entry.data = load_fmt;
      WB_SEL_PC4:  push_entry.data = res_pc4;
      default:     push_entry.data = res_alu;
    endcase
  end

  // Ready only opens on the first edge after reset releases.
  assign res_ready = rst && rdy_en && !q_full;
  assign push      = res_valid && res_ready && (res_rd != 5'd0);
  assign rf_we     = rst && !q_empty && !wb_hold;

  wb_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_entry(push_entry),
    .pop       (rf_we),
    .full      (q_full),
    .empty     (q_empty),
    .head      (head)
  );

  assign rf_rd_addr = q_empty ? last_entry.rd   : head.rd;
  assign rf_rd_din  = q_empty ? last_entry.data : head.data;

  assign issue_ready = (cnt[issue_rd] != {CW{1'b1}});
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != 5'd0);
  assign rs1_busy    = (cnt[chk_rs1] != '0);
  assign rs2_busy    = (cnt[chk_rs2] != '0);

  always_comb begin
    busy_mask = '0;
    for (int i = 1; i < 32; i++) begin
      busy_mask[i] = (cnt[i] != '0);
    end
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_fire) inc_vec[issue_rd] = 1'b1;
    if (rf_we)      dec_vec[head.rd]  = 1'b1;
  end

  // Same-edge issue and commit on one register cancel; decrement saturates at 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdy_en     <= 1'b0;
      last_entry <= '0;
      for (int i = 0; i < 32; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      rdy_en <= 1'b1;
      if (!q_empty) last_entry <= head;
      for (int i = 0; i < 32; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else if (dec_vec[i] && !inc_vec[i] && (cnt[i] != '0)) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: a cycle model with an expected-write queue checks
// every cycle, plus table-driven formatting vectors and hand-written corner sequences.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        res_valid;
  logic        res_ready;
  logic [4:0]  res_rd;
  logic [1:0]  res_sel;
  logic [31:0] res_alu;
  logic [31:0] res_load;
  logic [31:0] res_pc4;
  logic [2:0]  res_funct3;
  logic        wb_hold;
  logic        rf_we;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_din;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [31:0] busy_mask;

  writeback_unit #(.QDEPTH(2), .CW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_ready(issue_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_rd     (res_rd),
    .res_sel    (res_sel),
    .res_alu    (res_alu),
    .res_load   (res_load),
    .res_pc4    (res_pc4),
    .res_funct3 (res_funct3),
    .wb_hold    (wb_hold),
    .rf_we      (rf_we),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_din  (rf_rd_din),
    .chk_rs1    (chk_rs1),
    .chk_rs2    (chk_rs2),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .busy_mask  (busy_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [31:0] pc4;
    logic [31:0] exp;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  exp_t        q[$];
  int          mcnt[32];
  logic        rdy_en   = 1'b0;
  logic        mon_on   = 1'b0;
  logic        acc_flag = 1'b0;
  logic [31:0] drv_exp;
  exp_t        last_wr  = '0;
  vec_t        vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Cycle model: compare the current cycle, then advance to the next edge.
  always @(negedge clk) begin
    logic        exp_ready;
    logic        exp_we;
    logic [31:0] m;
    exp_t        hd;
    if (mon_on) begin
      exp_ready = rst && rdy_en && (q.size() < 2);
      exp_we    = rst && (q.size() != 0) && !wb_hold;
      m = '0;
      for (int i = 1; i < 32; i++) m[i] = (mcnt[i] != 0);
      check("mon_res_ready", {31'd0, res_ready}, {31'd0, exp_ready});
      check("mon_rf_we", {31'd0, rf_we}, {31'd0, exp_we});
      check("mon_busy_mask", busy_mask, m);
      check("mon_issue_ready", {31'd0, issue_ready}, {31'd0, mcnt[issue_rd] != 3});
      check("mon_rs1_busy", {31'd0, rs1_busy}, {31'd0, mcnt[chk_rs1] != 0});
      check("mon_rs2_busy", {31'd0, rs2_busy}, {31'd0, mcnt[chk_rs2] != 0});
      hd = (q.size() != 0) ? q[0] : last_wr;
      check("mon_rf_rd_addr", {27'd0, rf_rd_addr}, {27'd0, hd.rd});
      check("mon_rf_rd_din", rf_rd_din, hd.data);
      acc_flag = res_valid && exp_ready;
      if (!rst) begin
        q.delete();
        for (int i = 0; i < 32; i++) mcnt[i] = 0;
        last_wr = '0;
        rdy_en  = 1'b0;
      end else begin
        if (q.size() != 0) last_wr = q[0];
        if (issue_valid && issue_rd != 0 && mcnt[issue_rd] != 3 &&
            !(exp_we && hd.rd == issue_rd)) begin
          mcnt[issue_rd]++;
        end
        if (exp_we && !(issue_valid && issue_rd == hd.rd && mcnt[hd.rd] != 3) &&
            mcnt[hd.rd] > 0) begin
          mcnt[hd.rd]--;
        end
        if (exp_we) void'(q.pop_front());
        if (acc_flag && res_rd != 5'd0) q.push_back({res_rd, drv_exp});
        rdy_en = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_rd    = rd;
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
  endtask

  // Returns at #1 after the accepting edge.
  task automatic send(input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                      input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc4,
                      input logic [31:0] exp);
    logic got;
    res_rd = rd; res_sel = sel; res_funct3 = f3;
    res_alu = alu; res_load = ld; res_pc4 = pc4;
    drv_exp = exp;
    res_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      got = acc_flag;
    end
    #1;
    res_valid = 1'b0;
    check("send_accept", {31'd0, got}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{5'd5,  2'b01, 3'b100, 32'h1111_0000, 32'h0000_0080, 32'h0000_2000, 32'h0000_0080};
    vecs[1]  = '{5'd5,  2'b01, 3'b001, 32'h1111_0001, 32'h0000_8001, 32'h0000_2004, 32'hFFFF_8001};
    vecs[2]  = '{5'd6,  2'b01, 3'b101, 32'h1111_0002, 32'hFFFF_8001, 32'h0000_2008, 32'h0000_8001};
    vecs[3]  = '{5'd6,  2'b01, 3'b010, 32'h1111_0003, 32'h89AB_CDEF, 32'h0000_200C, 32'h89AB_CDEF};
    vecs[4]  = '{5'd8,  2'b01, 3'b011, 32'h1111_0004, 32'hCAFE_F00D, 32'h0000_2010, 32'hCAFE_F00D};
    vecs[5]  = '{5'd8,  2'b01, 3'b110, 32'h1111_0005, 32'hFFFF_FF91, 32'h0000_2014, 32'hFFFF_FF91};
    vecs[6]  = '{5'd8,  2'b01, 3'b000, 32'h1111_0006, 32'hAAAA_AA7F, 32'h0000_2018, 32'h0000_007F};
    vecs[7]  = '{5'd9,  2'b00, 3'b000, 32'h1111_1111, 32'h0000_00FF, 32'h0000_201C, 32'h1111_1111};
    vecs[8]  = '{5'd9,  2'b11, 3'b001, 32'h2222_2222, 32'h0000_80FF, 32'h0000_2020, 32'h2222_2222};
    vecs[9]  = '{5'd10, 2'b10, 3'b000, 32'h3333_3333, 32'h0000_0081, 32'h0000_1004, 32'h0000_1004};
    vecs[10] = '{5'd10, 2'b01, 3'b001, 32'h4444_4444, 32'hFFFF_7FFF, 32'h0000_2028, 32'h0000_7FFF};
    vecs[11] = '{5'd11, 2'b00, 3'b100, 32'h5555_5555, 32'h0000_0080, 32'h0000_202C, 32'h5555_5555};

    for (int i = 0; i < 32; i++) mcnt[i] = 0;
    rst = 1'b0; issue_valid = 1'b0; issue_rd = 5'd0; wb_hold = 1'b0;
    res_valid = 1'b1; res_rd = 5'd3; res_sel = 2'b00; res_funct3 = 3'b000;
    res_alu = 32'h0BAD_0003; res_load = '0; res_pc4 = '0; drv_exp = 32'h0BAD_0003;
    chk_rs1 = 5'd5; chk_rs2 = 5'd7;

    // Reset held two cycles with a result offered.
    @(posedge clk); #1 mon_on = 1'b1;
    @(negedge clk);
    check("rst_we", {31'd0, rf_we}, 32'd0);
    check("rst_mask", busy_mask, 32'd0);
    check("rst_res_ready", {31'd0, res_ready}, 32'd0);
    tick();
    rst = 1'b1; res_valid = 1'b0; issue_rd = 5'd7;
    @(negedge clk);
    check("rel_res_ready_early", {31'd0, res_ready}, 32'd0);
    check("rel_issue_ready", {31'd0, issue_ready}, 32'd1);
    check("rel_addr", {27'd0, rf_rd_addr}, 32'd0);
    check("rel_din", rf_rd_din, 32'd0);
    tick();
    @(negedge clk);
    check("rel_res_ready", {31'd0, res_ready}, 32'd1);
    tick();

    // LB of 0x80 to r5 with hazard tracking.
    issue(5'd5);
    @(negedge clk);
    check("lb_busy_before", {31'd0, rs1_busy}, 32'd1);
    tick();
    send(5'd5, 2'b01, 3'b000, 32'h0000_1234, 32'h0000_0080, 32'h0000_0004, 32'hFFFF_FF80);
    @(negedge clk);
    check("lb_we", {31'd0, rf_we}, 32'd1);
    check("lb_din", rf_rd_din, 32'hFFFF_FF80);
    check("lb_busy_pending", {31'd0, rs1_busy}, 32'd1);
    tick();
    @(negedge clk);
    check("lb_busy_after", {31'd0, rs1_busy}, 32'd0);
    check("lb_we_after", {31'd0, rf_we}, 32'd0);
    tick();

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].rd);
      send(vecs[i].rd, vecs[i].sel, vecs[i].f3, vecs[i].alu, vecs[i].ld, vecs[i].pc4, vecs[i].exp);
      @(negedge clk);
      check($sformatf("vec%0d_we", i), {31'd0, rf_we}, 32'd1);
      check($sformatf("vec%0d_addr", i), {27'd0, rf_rd_addr}, {27'd0, vecs[i].rd});
      check($sformatf("vec%0d_din", i), rf_rd_din, vecs[i].exp);
      tick();
    end

    // Back-to-back results: push and pop on a one-entry queue.
    for (int i = 0; i < 4; i++) begin
      send(5'(12 + i), 2'b00, 3'b000, 32'hB0B0_0000 + i, 32'h0, 32'h0, 32'hB0B0_0000 + i);
    end
    tick(); tick();

    // x0 issue and result are ignored.
    issue(5'd0);
    @(negedge clk);
    check("x0_mask", busy_mask, 32'd0);
    tick();
    send(5'd0, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("x0_no_we", {31'd0, rf_we}, 32'd0);
      tick();
    end

    // Hold fills the queue; release drains r1 then r2.
    issue(5'd1); issue(5'd2);
    wb_hold = 1'b1;
    send(5'd1, 2'b00, 3'b000, 32'h0000_0101, 32'h0, 32'h0, 32'h0000_0101);
    send(5'd2, 2'b00, 3'b000, 32'h0000_0202, 32'h0, 32'h0, 32'h0000_0202);
    res_rd = 5'd3; res_alu = 32'h0000_0303; drv_exp = 32'h0000_0303; res_valid = 1'b1;
    @(negedge clk);
    check("full_res_ready", {31'd0, res_ready}, 32'd0);
    check("full_we", {31'd0, rf_we}, 32'd0);
    tick();
    wb_hold = 1'b0; res_valid = 1'b0;
    @(negedge clk);
    check("drain1_we", {31'd0, rf_we}, 32'd1);
    check("drain1_addr", {27'd0, rf_rd_addr}, 32'd1);
    check("drain1_res_ready", {31'd0, res_ready}, 32'd0);
    tick();
    @(negedge clk);
    check("drain2_addr", {27'd0, rf_rd_addr}, 32'd2);
    check("drain2_din", rf_rd_din, 32'h0000_0202);
    check("drain2_res_ready", {31'd0, res_ready}, 32'd1);
    tick();
    @(negedge clk);
    check("hold_last_addr", {27'd0, rf_rd_addr}, 32'd2);
    check("hold_last_din", rf_rd_din, 32'h0000_0202);
    tick();

    // Counter limits and same-edge issue/commit on r7.
    issue(5'd7); issue(5'd7);
    wb_hold = 1'b1;
    send(5'd7, 2'b00, 3'b000, 32'h0000_0777, 32'h0, 32'h0, 32'h0000_0777);
    issue_rd = 5'd7; issue_valid = 1'b1; wb_hold = 1'b0;
    @(negedge clk);
    check("same_edge_we", {31'd0, rf_we}, 32'd1);
    tick();
    issue_valid = 1'b0;
    @(negedge clk);
    check("same_edge_mask7", {31'd0, busy_mask[7]}, 32'd1);
    check("same_edge_ready", {31'd0, issue_ready}, 32'd1);
    tick();
    issue(5'd7);
    @(negedge clk);
    check("cnt3_issue_ready", {31'd0, issue_ready}, 32'd0);
    check("cnt3_rs2_busy", {31'd0, rs2_busy}, 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      send(5'd7, 2'b10, 3'b000, 32'h0, 32'h0, 32'h0000_7000 + i, 32'h0000_7000 + i);
    end
    tick();
    @(negedge clk);
    check("cnt_drained_mask7", {31'd0, busy_mask[7]}, 32'd0);
    check("cnt_drained_ready", {31'd0, issue_ready}, 32'd1);
    tick();

    // Stray write to an idle register saturates at zero.
    send(5'd4, 2'b00, 3'b000, 32'h0000_0444, 32'h0, 32'h0, 32'h0000_0444);
    tick();
    @(negedge clk);
    check("stray_mask", busy_mask, 32'd0);
    tick();

    // Reset with two entries queued.
    issue(5'd1); issue(5'd2);
    wb_hold = 1'b1;
    send(5'd1, 2'b00, 3'b000, 32'h0000_1111, 32'h0, 32'h0, 32'h0000_1111);
    send(5'd2, 2'b00, 3'b000, 32'h0000_2222, 32'h0, 32'h0, 32'h0000_2222);
    rst = 1'b0; wb_hold = 1'b0;
    @(negedge clk);
    check("midrst_we", {31'd0, rf_we}, 32'd0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_mask", busy_mask, 32'd0);
    check("midrst_we_after", {31'd0, rf_we}, 32'd0);
    check("midrst_addr", {27'd0, rf_rd_addr}, 32'd0);
    check("midrst_din", rf_rd_din, 32'd0);
    tick();
    @(negedge clk);
    check("midrst_empty_we", {31'd0, rf_we}, 32'd0);
    check("midrst_res_ready", {31'd0, res_ready}, 32'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
